// File: rtl/turn_signal_pkg.sv
// Shared state codes and lever encodings for the turn-signal controller.
package turn_signal_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RIGHT  = 3'd1,
    ST_LEFT   = 3'd2,
    ST_HAZARD = 3'd3,
    ST_LANE_R = 3'd5,
    ST_LANE_L = 3'd6
  } state_t;

  localparam logic [1:0] ADI_OFF     = 2'b00;
  localparam logic [1:0] ADI_RIGHT   = 2'b01;
  localparam logic [1:0] ADI_LEFT    = 2'b10;
  localparam logic [1:0] ADI_INVALID = 2'b11;

endpackage

// File: rtl/turn_signal_ctrl_if.sv
// Lever/emergency inputs and lamp/status outputs of the turn-signal controller.
interface turn_signal_ctrl_if;
  logic       E;
  logic [1:0] ADI;
  logic       D;
  logic       I;
  logic [2:0] Status;
  logic       blink_tick;

  modport master (output E, ADI, input D, I, Status, blink_tick);
  modport slave  (input E, ADI, output D, I, Status, blink_tick);
endinterface

// File: rtl/turn_signal_ctrl_blink_timebase.sv
// Blink half-period counter, lamp phase and completed on-pulse counter.
module blink_timebase #(
  parameter int unsigned HALF         = 10,
  parameter int unsigned LANE_FLASHES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic phase,
  output logic blink_tick,
  output logic [$clog2(LANE_FLASHES+1)-1:0] flash_cnt
);

  localparam int unsigned CW = $clog2(HALF);
  localparam int unsigned FW = $clog2(LANE_FLASHES+1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap       = (cnt == CW'(HALF-1));
  assign blink_tick = wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      phase     <= 1'b0;
      flash_cnt <= '0;
    end else if (restart) begin
      cnt       <= '0;
      phase     <= 1'b1;
      flash_cnt <= '0;
    end else if (!run) begin
      cnt       <= '0;
      phase     <= 1'b0;
      flash_cnt <= '0;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= ~phase;
      // only an on->off toggle completes a flash
      if (phase && (flash_cnt != FW'(LANE_FLASHES)))
        flash_cnt <= flash_cnt + FW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn-signal / hazard controller with one-touch lane-change flashing.
module turn_signal_ctrl
  import turn_signal_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BLINK_HZ     = 1,
  parameter int unsigned LANE_FLASHES = 3
) (
  input logic               clk,
  input logic               reset,
  turn_signal_ctrl_if.slave bus
);

  localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned FW   = $clog2(LANE_FLASHES+1);

  if (HALF < 2) begin : g_half_check
    $error("turn_signal_ctrl: HALF must be at least 2");
  end

  logic [1:0] e_sync;
  logic [1:0] adi_s1, adi_s2;
  logic       e_s;
  logic [1:0] lever;

  state_t  state, state_nx;
  logic    restart, run;
  logic    phase, tick, lane_done;
  logic [FW-1:0] flash_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_sync <= '0;
      adi_s1 <= '0;
      adi_s2 <= '0;
    end else begin
      e_sync <= {e_sync[0], bus.E};
      adi_s1 <= bus.ADI;
      adi_s2 <= adi_s1;
    end
  end

  assign e_s   = e_sync[1];
  assign lever = (adi_s2 == ADI_INVALID) ? ADI_OFF : adi_s2;

  // final flash: the phase is about to fall and this completes the last pulse
  assign lane_done = tick && phase && (flash_cnt >= FW'(LANE_FLASHES-1));

  always_comb begin
    state_nx = state;
    if (e_s) begin
      state_nx = ST_HAZARD;
    end else begin
      unique case (state)
        ST_OFF: begin
          if (lever == ADI_RIGHT)     state_nx = ST_RIGHT;
          else if (lever == ADI_LEFT) state_nx = ST_LEFT;
        end
        ST_RIGHT: begin
          if (lever == ADI_LEFT)     state_nx = ST_LEFT;
          else if (lever == ADI_OFF) state_nx = (flash_cnt == '0) ? ST_LANE_R : ST_OFF;
        end
        ST_LEFT: begin
          if (lever == ADI_RIGHT)    state_nx = ST_RIGHT;
          else if (lever == ADI_OFF) state_nx = (flash_cnt == '0) ? ST_LANE_L : ST_OFF;
        end
        ST_HAZARD: begin
          if (lever == ADI_RIGHT)     state_nx = ST_RIGHT;
          else if (lever == ADI_LEFT) state_nx = ST_LEFT;
          else                        state_nx = ST_OFF;
        end
        ST_LANE_R, ST_LANE_L: begin
          if (lever == ADI_RIGHT)     state_nx = ST_RIGHT;
          else if (lever == ADI_LEFT) state_nx = ST_LEFT;
          else if (lane_done)         state_nx = ST_OFF;
        end
        default: state_nx = ST_OFF;
      endcase
    end
  end

  // restart is derived from the next state so the lamp lights on entry
  assign restart = (state_nx inside {ST_RIGHT, ST_LEFT, ST_HAZARD}) && (state_nx != state);
  assign run     = (state_nx != ST_OFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_OFF;
    else        state <= state_nx;
  end

  blink_timebase #(
    .HALF         (HALF),
    .LANE_FLASHES (LANE_FLASHES)
  ) u_timebase (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .run        (run),
    .phase      (phase),
    .blink_tick (tick),
    .flash_cnt  (flash_cnt)
  );

  assign bus.Status     = state;
  assign bus.blink_tick = tick;
  assign bus.D = phase && (state inside {ST_RIGHT, ST_LANE_R, ST_HAZARD});
  assign bus.I = phase && (state inside {ST_LEFT,  ST_LANE_L, ST_HAZARD});

endmodule

// File: doc/turn_signal_ctrl.md
Name: turn_signal_ctrl

Overview:
Parametrised turn-signal/hazard controller with one-touch lane-change support; drives right and left lamp outputs from the lever and the emergency switch. It replaces the fixed 1 Hz divided-clock design: all logic runs on the board clock, and blink timing uses a clock-enable tick instead of a derived clock. It adds input synchronisers, a blink-phase restart on mode entry, and a lane-change mode that flashes a set number of times and then cancels itself.

Parameters:
CLK_HZ, 50_000_000, board clock frequency in Hz
BLINK_HZ, 1, blink frequency; one on half-period plus one off half-period per cycle
LANE_FLASHES, 3, number of on-pulses emitted in lane-change mode (>=1)
Derived: HALF = CLK_HZ/(2*BLINK_HZ) clock cycles per half-period; must be >=2, checked at elaboration.

Ports:
clk  in  1  board clock
reset  in  1  asynchronous, active-low reset
E  in  1  emergency switch (asynchronous; highest priority)
ADI  in  2  lever: 00 off, 01 right, 10 left, 11 invalid (treated as 00)
D  out  1  right lamp
I  out  1  left lamp
Status  out  3  current state code
blink_tick  out  1  one-cycle pulse on every blink phase toggle

Behaviour:
- Reset (reset=0): asynchronous. State=OFF, half-period counter=0, phase=0, flash count=0, synchronisers=0. Outputs D=0, I=0, Status=0, blink_tick=0 while reset is asserted.
- E and ADI pass through 2-flop synchronisers. Outputs are Moore-decoded from registered state/phase. Input-change-to-output latency is 3 clk cycles.
- State codes on Status: OFF=0, RIGHT=1, LEFT=2, HAZARD=3, LANE_R=5, LANE_L=6.
- Transitions are evaluated every cycle on synced inputs, in priority order:
  - e_s=1: go to HAZARD from any state.
  - HAZARD with e_s=0: lever 01 -> RIGHT, lever 10 -> LEFT, otherwise -> OFF.
  - OFF: lever 01 -> RIGHT, lever 10 -> LEFT, lever 00/11 -> stay in OFF.
  - RIGHT (mirror for LEFT):
    - lever 10 -> LEFT.
    - lever 00/11 with flash count=0 (no on-pulse completed yet): this is a tap -> LANE_R.
    - lever 00/11 with flash count>0 -> OFF.
  - LANE_R (mirror for LANE_L):
    - lever 01 -> RIGHT.
    - lever 10 -> LEFT.
    - flash count reaches LANE_FLASHES -> OFF; this is checked on the cycle the phase goes 1->0.
- Blink timebase:
  - In OFF the counter and phase are held at 0.
  - Entering RIGHT, LEFT or HAZARD from a different state restarts the timebase: counter=0, phase=1, flash count=0. The lamp lights in the first cycle of the new state.
  - RIGHT->LANE_R (and LEFT->LANE_L) continues the phase and flash count without restarting.
  - Counter counts 0..HALF-1. At HALF-1 it wraps to 0, phase toggles, and blink_tick=1 for that cycle.
  - Flash count increments on each phase 1->0 toggle and saturates at LANE_FLASHES.
- Outputs:
  - D = phase when state is RIGHT, LANE_R or HAZARD; 0 otherwise.
  - I = phase when state is LEFT, LANE_L or HAZARD; 0 otherwise.
  - In HAZARD, D and I are always identical.
- Simultaneous events: E has priority over lane termination and lever changes. A lever change and the final flash in the same cycle follow the lever.
- A reset assertion in the middle of any mode aborts it immediately; after release the block starts in OFF.

Decomposition:
- Shared package turn_signal_pkg holds:
  - the state code localparams (3-bit);
  - ADI code constants (ADI_OFF, ADI_RIGHT, ADI_LEFT, ADI_INVALID).
- Sub-module blink_timebase holds the counter, phase, restart, tick and flash counter. It is parameterised by HALF and LANE_FLASHES. Its ports are restart, run, phase, blink_tick and flash_cnt.

Test Plan:
All scenarios use CLK_HZ=20, BLINK_HZ=1 (HALF=10), LANE_FLASHES=3.
1. OFF, ADI=01 held from cycle 0 -> Status=1 from cycle 3; D=1 for cycles 3-12, 0 for 13-22, then repeating; I=0 throughout; blink_tick pulses at cycles 12, 22, ...
2. Tap: ADI=01 for cycles 0-3, then 00 -> Status=1, then 5 without a phase restart. D gives exactly 3 on-pulses of 10 cycles each. Status=0 and D=0 on the cycle of the 3rd on->off toggle.
3. ADI=01 held 30 cycles (flash count>0), then 00 -> Status=0 three cycles after release; LANE_R is never entered.
4. In RIGHT mid-on-phase, E=1 -> Status=3 at +3 cycles with a phase restart, D=I=1 for 10 cycles. Then E=0 with ADI=10 -> Status=2 with a phase restart; D=0.
5. ADI=11 from OFF -> Status stays 0, D=I=0, no blink_tick. LANE_L with ADI=10 re-asserted -> Status=2 with a phase restart.
6. Reset driven low asynchronously mid-hazard (between clock edges) -> D=I=0, Status=0 with no clock edge. After release the block stays in OFF until the lever or E is asserted.
